// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Owns the single register file write port (A_3/WD_3/
//               Reg_Write_W). After reset it optionally clears registers
//               1..DEPTH-1, then arbitrates between the writeback stage
//               (highest priority) and a small FIFO of long-latency unit
//               results. It reports pending FIFO writes that match decode
//               source registers, and asks for a stall when the FIFO head
//               has waited too long.
// Ports       : clk, rst                        - clock, sync active-high reset
//               WB_En/WB_Addr/WB_Data           - writeback write request
//               LU_Valid/LU_Addr/LU_Data/LU_Ready - LU result handshake
//               Rs_D, Rt_D -> Rs_Hit, Rt_Hit    - pending-write hit checks
//               Stall_Req, Init_Done            - hazard / status outputs
//               A_3, WD_3, Reg_Write_W          - register file write port
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 8,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WB_En,
    input  logic [4:0]       WB_Addr,
    input  logic [WIDTH-1:0] WB_Data,
    input  logic             LU_Valid,
    input  logic [4:0]       LU_Addr,
    input  logic [WIDTH-1:0] LU_Data,
    output logic             LU_Ready,
    input  logic [4:0]       Rs_D,
    input  logic [4:0]       Rt_D,
    output logic             Rs_Hit,
    output logic             Rt_Hit,
    output logic             Stall_Req,
    output logic             Init_Done,
    output logic [4:0]       A_3,
    output logic [WIDTH-1:0] WD_3,
    output logic             Reg_Write_W
);

    localparam int c_AW = 5;
    localparam int c_PW = $clog2(BUF_DEPTH);
    localparam int c_GW = $clog2(STARVE_MAX + 1);

    localparam logic [c_AW-1:0] c_LAST_REG  = c_AW'(DEPTH - 1);
    localparam logic [c_PW:0]   c_FULL_CNT  = (c_PW + 1)'(BUF_DEPTH);
    localparam logic [c_GW-1:0] c_AGE_MAX   = c_GW'(STARVE_MAX);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [c_AW-1:0]  r_cnt;
    logic [c_AW-1:0]  r_buf_addr [BUF_DEPTH];
    logic [WIDTH-1:0] r_buf_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] r_buf_vld;
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW:0]    r_count;
    logic [c_GW-1:0]  r_age;

    logic w_empty;
    logic w_full;
    logic w_wb_req;
    logic w_push;
    logic w_pop;
    logic [BUF_DEPTH-1:0] w_rs_match;
    logic [BUF_DEPTH-1:0] w_rt_match;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL_CNT);
    // A write to r0 is architecturally a no-op, so it never claims the port.
    assign w_wb_req = WB_En && (WB_Addr != '0);
    // Results for r0 are handshaken but dropped, so they cannot block the port.
    assign w_push   = LU_Valid && LU_Ready && (LU_Addr != '0);

    // ------------------------------------------------------------------
    // State register and clear counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT_EN ? S_INIT : S_RUN;
            r_cnt   <= c_AW'(1);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and write-port mux. Outputs are forced low while rst is
    // high, because the state register already holds INIT during reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        A_3         = '0;
        WD_3        = '0;
        Reg_Write_W = 1'b0;
        LU_Ready    = 1'b0;
        Stall_Req   = 1'b0;
        Init_Done   = 1'b0;
        w_pop       = 1'b0;
        if (!rst) begin
            case (r_state)
                S_INIT: begin
                    A_3         = r_cnt;
                    Reg_Write_W = 1'b1;
                    Stall_Req   = 1'b1;
                    if (r_cnt == c_LAST_REG) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    Init_Done = 1'b1;
                    LU_Ready  = !w_full;
                    Stall_Req = (r_age == c_AGE_MAX);
                    if (w_wb_req) begin
                        A_3         = WB_Addr;
                        WD_3        = WB_Data;
                        Reg_Write_W = 1'b1;
                    end else if (!w_empty) begin
                        A_3         = r_buf_addr[r_rd_ptr];
                        WD_3        = r_buf_data[r_rd_ptr];
                        Reg_Write_W = 1'b1;
                        w_pop       = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // LU result FIFO. Push and pop slots never coincide: equal pointers
    // mean empty (no pop) or full (no push).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_buf_vld <= '0;
            r_age     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr            <= r_wr_ptr + 1'b1;
                r_buf_vld[r_wr_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr            <= r_rd_ptr + 1'b1;
                r_buf_vld[r_rd_ptr] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Head age: only a head that is present and not leaving ages.
            if (w_pop || w_empty) begin
                r_age <= '0;
            end else if (r_age != c_AGE_MAX) begin
                r_age <= r_age + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_addr[r_wr_ptr] <= LU_Addr;
            r_buf_data[r_wr_ptr] <= LU_Data;
        end
    end

    // ------------------------------------------------------------------
    // Pending-write hits against every valid entry (registered state only,
    // so an entry accepted this cycle shows up next cycle).
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < BUF_DEPTH; i++) begin : g_hit
            assign w_rs_match[i] = r_buf_vld[i] && (r_buf_addr[i] == Rs_D);
            assign w_rt_match[i] = r_buf_vld[i] && (r_buf_addr[i] == Rt_D);
        end
    endgenerate

    assign Rs_Hit = !rst && (Rs_D != '0) && (|w_rs_match);
    assign Rt_Hit = !rst && (Rt_D != '0) && (|w_rt_match);

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Self-checking bench for rf_write_arbiter. Expected register
//               file writes are queued when stimulus is driven and compared
//               on the falling edge whenever the port writes in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_En;
    logic [4:0]  WB_Addr;
    logic [31:0] WB_Data;
    logic        LU_Valid;
    logic [4:0]  LU_Addr;
    logic [31:0] LU_Data;
    logic        LU_Ready;
    logic [4:0]  Rs_D;
    logic [4:0]  Rt_D;
    logic        Rs_Hit;
    logic        Rt_Hit;
    logic        Stall_Req;
    logic        Init_Done;
    logic [4:0]  A_3;
    logic [31:0] WD_3;
    logic        Reg_Write_W;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total  = 0;
    int  passed = 0;
    bit  sb_on  = 1'b0;

    rf_write_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .WB_En       (WB_En),
        .WB_Addr     (WB_Addr),
        .WB_Data     (WB_Data),
        .LU_Valid    (LU_Valid),
        .LU_Addr     (LU_Addr),
        .LU_Data     (LU_Data),
        .LU_Ready    (LU_Ready),
        .Rs_D        (Rs_D),
        .Rt_D        (Rt_D),
        .Rs_Hit      (Rs_Hit),
        .Rt_Hit      (Rt_Hit),
        .Stall_Req   (Stall_Req),
        .Init_Done   (Init_Done),
        .A_3         (A_3),
        .WD_3        (WD_3),
        .Reg_Write_W (Reg_Write_W)
    );

    always #5 clk = ~clk;

    // Scoreboard: every RUN-mode write must match the oldest expectation.
    always @(negedge clk) begin : sb_mon
        wr_t e;
        if (sb_on && Reg_Write_W) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: wrote A_3=%0d WD_3=%h, required no write", A_3, WD_3);
            end else begin
                e = exp_q.pop_front();
                if (A_3 !== e.addr || WD_3 !== e.data)
                    $display("FAIL sb_write: got A_3=%0d WD_3=%h, required A_3=%0d WD_3=%h",
                             A_3, WD_3, e.addr, e.data);
                else
                    passed++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        WB_En = 1'b0; WB_Addr = '0; WB_Data = '0;
        LU_Valid = 1'b0; LU_Addr = '0; LU_Data = '0;
        Rs_D = '0; Rt_D = '0;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Reset outputs, then the full clear sequence with WB/LU traffic ignored.
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        total++;
        if (Reg_Write_W !== 1'b0 || LU_Ready !== 1'b0 || Stall_Req !== 1'b0 ||
            Init_Done !== 1'b0 || Rs_Hit !== 1'b0 || Rt_Hit !== 1'b0)
            $display("FAIL reset_outputs: got we=%b rdy=%b stall=%b done=%b hits=%b%b, required all 0",
                     Reg_Write_W, LU_Ready, Stall_Req, Init_Done, Rs_Hit, Rt_Hit);
        else
            passed++;
        step();
        rst = 1'b0;
        WB_En = 1'b1; WB_Addr = 5'd3; WB_Data = 32'hDEAD_BEEF;
        LU_Valid = 1'b1; LU_Addr = 5'd4; LU_Data = 32'h1234_5678; Rs_D = 5'd4;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            total++;
            if (Reg_Write_W !== 1'b1 || A_3 !== 5'(k) || WD_3 !== 32'h0 || Stall_Req !== 1'b1 ||
                Init_Done !== 1'b0 || LU_Ready !== 1'b0 || Rs_Hit !== 1'b0)
                $display("FAIL init_step[%0d]: got we=%b A_3=%0d WD_3=%h stall=%b done=%b rdy=%b rs=%b, required 1 %0d 0 1 0 0 0",
                         k, Reg_Write_W, A_3, WD_3, Stall_Req, Init_Done, LU_Ready, Rs_Hit, k);
            else
                passed++;
            step();
        end
        idle_inputs();
        @(negedge clk);
        total++;
        if (Init_Done !== 1'b1 || Stall_Req !== 1'b0 || Reg_Write_W !== 1'b0 || LU_Ready !== 1'b1)
            $display("FAIL init_done: got done=%b stall=%b we=%b rdy=%b, required 1 0 0 1",
                     Init_Done, Stall_Req, Reg_Write_W, LU_Ready);
        else
            passed++;
        step();
    endtask

    // WB wins the port; the LU result waits and writes on the first idle WB cycle.
    task automatic test_wb_lu();
        logic e_we, e_rs;
        sb_on = 1'b1;
        for (int n = 0; n <= 3; n++) begin
            idle_inputs();
            Rs_D = 5'd7;
            if (n == 0) begin
                WB_En = 1'b1; WB_Addr = 5'd5; WB_Data = 32'h0000_0555; expect_wr(5'd5, 32'h0000_0555);
                LU_Valid = 1'b1; LU_Addr = 5'd7; LU_Data = 32'h0000_0777;
            end else if (n == 1) begin
                WB_En = 1'b1; WB_Addr = 5'd6; WB_Data = 32'h0000_0666; expect_wr(5'd6, 32'h0000_0666);
            end else if (n == 2) begin
                expect_wr(5'd7, 32'h0000_0777);
            end
            e_we = (n <= 2);
            e_rs = (n == 1) || (n == 2);
            @(negedge clk);
            total++;
            if (Reg_Write_W !== e_we || LU_Ready !== 1'b1 || Rs_Hit !== e_rs || Rt_Hit !== 1'b0)
                $display("FAIL wb_lu[%0d]: got we=%b rdy=%b rs=%b rt=%b, required we=%b rdy=1 rs=%b rt=0",
                         n, Reg_Write_W, LU_Ready, Rs_Hit, Rt_Hit, e_we, e_rs);
            else
                passed++;
            step();
        end
    endtask

    // WB holds the port: FIFO fills, head starves, stall, then in-order drain.
    task automatic test_fill_starve();
        logic e_we, e_rdy, e_stall, e_rs, e_rt;
        for (int n = 0; n <= 12; n++) begin
            idle_inputs();
            Rs_D = 5'd11; Rt_D = 5'd10;
            if (n <= 9) begin
                WB_En = 1'b1; WB_Addr = 5'd9; WB_Data = 32'h9000_0000 + 32'(n);
                expect_wr(5'd9, 32'h9000_0000 + 32'(n));
                LU_Valid = 1'b1;
                LU_Addr  = (n == 0) ? 5'd10 : (n == 1) ? 5'd11 : 5'd12;
                LU_Data  = (n == 0) ? 32'hAAAA_0010 : (n == 1) ? 32'hBBBB_0011 : 32'hCCCC_0012;
            end
            if (n == 10) expect_wr(5'd10, 32'hAAAA_0010);
            if (n == 11) expect_wr(5'd11, 32'hBBBB_0011);
            e_we    = (n <= 11);
            e_rdy   = (n <= 1) || (n >= 11);
            e_stall = (n == 9) || (n == 10);
            e_rs    = (n >= 2) && (n <= 11);
            e_rt    = (n >= 1) && (n <= 10);
            @(negedge clk);
            total++;
            if (Reg_Write_W !== e_we || LU_Ready !== e_rdy || Stall_Req !== e_stall ||
                Rs_Hit !== e_rs || Rt_Hit !== e_rt)
                $display("FAIL fill_starve[%0d]: got we=%b rdy=%b stall=%b rs=%b rt=%b, required %b %b %b %b %b",
                         n, Reg_Write_W, LU_Ready, Stall_Req, Rs_Hit, Rt_Hit,
                         e_we, e_rdy, e_stall, e_rs, e_rt);
            else
                passed++;
            step();
        end
    endtask

    // Address-0 requests: WB to r0 lets the FIFO drain, LU to r0 is dropped.
    task automatic test_zero_addr();
        logic e_we, e_rs;
        for (int n = 0; n <= 3; n++) begin
            idle_inputs();
            Rs_D = 5'd13;
            if (n <= 2) begin
                WB_En = 1'b1; WB_Addr = 5'd0; WB_Data = 32'hFFFF_FFFF;
                LU_Valid = 1'b1;
                LU_Addr  = (n == 0) ? 5'd13 : 5'd0;
                LU_Data  = (n == 0) ? 32'h0000_1313 : 32'hEEEE_0000;
            end
            if (n == 1) expect_wr(5'd13, 32'h0000_1313);
            e_we = (n == 1);
            e_rs = (n == 1);
            @(negedge clk);
            total++;
            if (Reg_Write_W !== e_we || LU_Ready !== 1'b1 || Rs_Hit !== e_rs || Rt_Hit !== 1'b0)
                $display("FAIL zero_addr[%0d]: got we=%b rdy=%b rs=%b rt=%b, required we=%b rdy=1 rs=%b rt=0",
                         n, Reg_Write_W, LU_Ready, Rs_Hit, Rt_Hit, e_we, e_rs);
            else
                passed++;
            step();
        end
    endtask

    // Push and pop in one cycle with one entry: occupancy stays 1, order A then B.
    task automatic test_back_to_back();
        logic e_we, e_rs, e_rt;
        for (int n = 0; n <= 3; n++) begin
            idle_inputs();
            Rs_D = 5'd22; Rt_D = 5'd21;
            if (n == 0) begin
                WB_En = 1'b1; WB_Addr = 5'd20; WB_Data = 32'h0000_2020; expect_wr(5'd20, 32'h0000_2020);
                LU_Valid = 1'b1; LU_Addr = 5'd21; LU_Data = 32'hA000_0021;
            end else if (n == 1) begin
                LU_Valid = 1'b1; LU_Addr = 5'd22; LU_Data = 32'hB000_0022;
                expect_wr(5'd21, 32'hA000_0021);
            end else if (n == 2) begin
                expect_wr(5'd22, 32'hB000_0022);
            end
            e_we = (n <= 2);
            e_rt = (n == 1);
            e_rs = (n == 2);
            @(negedge clk);
            total++;
            if (Reg_Write_W !== e_we || LU_Ready !== 1'b1 || Rs_Hit !== e_rs || Rt_Hit !== e_rt)
                $display("FAIL back_to_back[%0d]: got we=%b rdy=%b rs=%b rt=%b, required we=%b rdy=1 rs=%b rt=%b",
                         n, Reg_Write_W, LU_Ready, Rs_Hit, Rt_Hit, e_we, e_rs, e_rt);
            else
                passed++;
            step();
        end
    endtask

    // Reset with a pending entry, then reset again mid-clear: clear restarts at r1.
    task automatic test_reset_mid_init();
        idle_inputs();
        Rs_D = 5'd25;
        WB_En = 1'b1; WB_Addr = 5'd1; WB_Data = 32'h0000_0101; expect_wr(5'd1, 32'h0000_0101);
        LU_Valid = 1'b1; LU_Addr = 5'd25; LU_Data = 32'h0000_2525;
        step();
        LU_Valid = 1'b0;
        WB_Data = 32'h0000_0102; expect_wr(5'd1, 32'h0000_0102);
        @(negedge clk);
        total++;
        if (Rs_Hit !== 1'b1) $display("FAIL pending_hit: got rs=%b, required 1", Rs_Hit);
        else passed++;
        step();
        total++;
        if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d writes outstanding, required 0", exp_q.size());
        else passed++;
        sb_on = 1'b0;
        WB_En = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (Reg_Write_W !== 1'b0 || Rs_Hit !== 1'b0 || Init_Done !== 1'b0 || LU_Ready !== 1'b0)
            $display("FAIL reset_run: got we=%b rs=%b done=%b rdy=%b, required all 0",
                     Reg_Write_W, Rs_Hit, Init_Done, LU_Ready);
        else
            passed++;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            total++;
            if (A_3 !== 5'(k) || Reg_Write_W !== 1'b1 || Rs_Hit !== 1'b0)
                $display("FAIL init_first[%0d]: got A_3=%0d we=%b rs=%b, required %0d 1 0", k, A_3, Reg_Write_W, Rs_Hit, k);
            else
                passed++;
            step();
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (Reg_Write_W !== 1'b0 || Stall_Req !== 1'b0)
            $display("FAIL reset_mid_init: got we=%b stall=%b, required 0 0", Reg_Write_W, Stall_Req);
        else
            passed++;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            total++;
            if (A_3 !== 5'(k) || Reg_Write_W !== 1'b1 || Init_Done !== 1'b0 || Stall_Req !== 1'b1)
                $display("FAIL init_restart[%0d]: got A_3=%0d we=%b done=%b stall=%b, required %0d 1 0 1",
                         k, A_3, Reg_Write_W, Init_Done, Stall_Req, k);
            else
                passed++;
            step();
        end
        @(negedge clk);
        total++;
        if (Init_Done !== 1'b1 || Stall_Req !== 1'b0 || LU_Ready !== 1'b1 || Rs_Hit !== 1'b0 || Reg_Write_W !== 1'b0)
            $display("FAIL restart_run: got done=%b stall=%b rdy=%b rs=%b we=%b, required 1 0 1 0 0",
                     Init_Done, Stall_Req, LU_Ready, Rs_Hit, Reg_Write_W);
        else
            passed++;
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_wb_lu();
        test_fill_starve();
        test_zero_addr();
        test_back_to_back();
        test_reset_mid_init();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, total);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
